// File: rtl/iic_slave.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, fixed 7-bit address match,
// byte delivery on writes and byte transmission on reads. SDA is open-drain, no stretching.
module iic_slave #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       addressed,
  output logic       rw,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StRx,
    StRxAck,
    StTx,
    StTxAck,
    StWaitStop
  } state_e;

  // Two-flop synchronizers plus one history flop per line.
  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;

  always_ff @(posedge clock) begin
    if (reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_h  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_h  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  always_comb begin
    scl_rise  = scl_s2 & ~scl_h;
    scl_fall  = ~scl_s2 & scl_h;
    start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;
  end

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  shreg_q, shreg_d;
  // ACK states: 0 = waiting first fall, 1 = inside slot (TxAck: master ACK seen).
  logic        phase_q, phase_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        addressed_q, addressed_d;
  logic        rw_q, rw_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_req_q, tx_req_d;
  logic [7:0]  byte_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shreg_q     <= '0;
      phase_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
      rw_q        <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      phase_q     <= phase_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      addressed_q <= addressed_d;
      rw_q        <= rw_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    phase_d     = phase_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    addressed_d = addressed_q;
    rw_d        = rw_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    byte_in     = {shreg_q, sda_s2};

    // Bus conditions take priority over any SCL edge in the same cycle.
    if (start_det) begin
      state_d     = StAddr;
      cnt_d       = '0;
      phase_d     = 1'b0;
      busy_d      = 1'b1;
      addressed_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d     = StIdle;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise) begin
            shreg_d = byte_in[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              // Address 0 (general call) is never matched.
              if (byte_in[7:1] == ADDR && byte_in[7:1] != 7'd0) begin
                rw_d    = byte_in[0];
                phase_d = 1'b0;
                state_d = StAddrAck;
              end else begin
                state_d = StWaitStop;
              end
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
              tx_req_d = rw_q;
            end else begin
              addressed_d = 1'b1;
              cnt_d       = '0;
              phase_d     = 1'b0;
              if (rw_q) begin
                shreg_d  = tx_data[6:0];
                sda_oe_d = ~tx_data[7];
                state_d  = StTx;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = StRx;
              end
            end
          end
        end
        StRx: begin
          if (scl_rise) begin
            shreg_d = byte_in[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              phase_d    = 1'b0;
              state_d    = StRxAck;
            end
          end
        end
        StRxAck: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              cnt_d    = '0;
              state_d  = StRx;
            end
          end
        end
        StTx: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
          end else if (scl_fall) begin
            // cnt wraps to 0 once all eight bits have been clocked out.
            if (cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              tx_req_d = 1'b1;
              phase_d  = 1'b0;
              state_d  = StTxAck;
            end else begin
              sda_oe_d = ~shreg_q[6];
              shreg_d  = {shreg_q[5:0], 1'b0};
            end
          end
        end
        StTxAck: begin
          if (scl_rise) begin
            if (sda_s2) begin
              state_d = StWaitStop;
            end else begin
              phase_d = 1'b1;
            end
          end else if (scl_fall && phase_q) begin
            shreg_d  = tx_data[6:0];
            sda_oe_d = ~tx_data[7];
            cnt_d    = '0;
            phase_d  = 1'b0;
            state_d  = StTx;
          end
        end
        StWaitStop: ;
        default: state_d = StIdle;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign addressed = addressed_q;
  assign rw        = rw_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;

endmodule

// File: tb/tb_iic_slave.sv
// Directed bench for iic_slave: a bus-master model drives SCL/SDA with an open-drain
// wired-AND SDA line and checks each scenario against hand-computed values.
module tb_iic_slave;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl   = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_bus;
  logic       sda_oe, busy, addressed, rw, rx_valid, tx_req;
  logic [7:0] rx_data;

  int tests = 0;
  int fails = 0;
  int txr_cnt = 0;
  int oe_cnt = 0;
  logic [7:0] rxv_q[$];

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clock = ~clock;

  iic_slave #(.ADDR(7'h50)) dut (
    .clock     (clock),
    .reset     (reset),
    .scl       (scl),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .addressed (addressed),
    .rw        (rw),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_req    (tx_req)
  );

  always @(negedge clock) begin
    if (rx_valid) rxv_q.push_back(rx_data);
    if (tx_req) txr_cnt++;
    if (sda_oe) oe_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Works from idle (SCL high) and as a repeated START (SCL low).
  task automatic bus_start();
    sda_m = 1'b1; wait_clk(4);
    scl = 1'b1;   wait_clk(8);
    sda_m = 1'b0; wait_clk(8);
    scl = 1'b0;   wait_clk(4);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(4);
    scl = 1'b1;   wait_clk(8);
    sda_m = 1'b1; wait_clk(8);
  endtask

  task automatic bit_io(input logic b, output logic s);
    sda_m = b; wait_clk(4);
    scl = 1'b1; wait_clk(4);
    s = sda_bus; wait_clk(4);
    scl = 1'b0; wait_clk(4);
  endtask

  task automatic byte_wr(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, ack);
  endtask

  task automatic byte_rd(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      d[i] = s;
    end
    bit_io(nack, s);
  endtask

  task automatic test_reset();
    reset = 1'b1; wait_clk(3);
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", busy); end
    tests++; if (addressed !== 1'b0) begin fails++; $display("FAIL rst_addressed got=%b exp=0", addressed); end
    tests++; if (rw !== 1'b0) begin fails++; $display("FAIL rst_rw got=%b exp=0", rw); end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL rst_rx_data got=%h exp=00", rx_data); end
    tests++; if ({rx_valid, tx_req} !== 2'b00) begin fails++; $display("FAIL rst_pulses got=%b exp=00", {rx_valid, tx_req}); end
    reset = 1'b0; wait_clk(4);
  endtask

  task automatic test_write();
    int   base;
    logic ack;
    base = rxv_q.size();
    bus_start();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy_start got=%b exp=1", busy); end
    tests++; if (addressed !== 1'b0) begin fails++; $display("FAIL wr_addressed_start got=%b exp=0", addressed); end
    byte_wr(8'hA0, ack);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL wr_addr_ack got=%b exp=0", ack); end
    tests++; if (addressed !== 1'b1) begin fails++; $display("FAIL wr_addressed got=%b exp=1", addressed); end
    tests++; if (rw !== 1'b0) begin fails++; $display("FAIL wr_rw got=%b exp=0", rw); end
    byte_wr(8'h3C, ack);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL wr_data1_ack got=%b exp=0", ack); end
    byte_wr(8'hC3, ack);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL wr_data2_ack got=%b exp=0", ack); end
    tests++; if (rxv_q.size() - base !== 2) begin fails++; $display("FAIL wr_rx_count got=%0d exp=2", rxv_q.size() - base); end
    if (rxv_q.size() - base >= 2) begin
      tests++; if (rxv_q[base] !== 8'h3C) begin fails++; $display("FAIL wr_rx0 got=%h exp=3c", rxv_q[base]); end
      tests++; if (rxv_q[base+1] !== 8'hC3) begin fails++; $display("FAIL wr_rx1 got=%h exp=c3", rxv_q[base+1]); end
    end
    tests++; if (addressed !== 1'b1) begin fails++; $display("FAIL wr_addressed_end got=%b exp=1", addressed); end
    bus_stop();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wr_busy_stop got=%b exp=0", busy); end
    tests++; if (addressed !== 1'b0) begin fails++; $display("FAIL wr_addressed_stop got=%b exp=0", addressed); end
  endtask

  task automatic test_mismatch();
    int   base_rx, base_oe;
    logic ack;
    base_rx = rxv_q.size();
    base_oe = oe_cnt;
    bus_start();
    byte_wr(8'hA4, ack);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL mm_addr_nack got=%b exp=1", ack); end
    byte_wr(8'h55, ack);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL mm_data_nack got=%b exp=1", ack); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mm_busy got=%b exp=1", busy); end
    tests++; if (addressed !== 1'b0) begin fails++; $display("FAIL mm_addressed got=%b exp=0", addressed); end
    bus_stop();
    tests++; if (oe_cnt !== base_oe) begin fails++; $display("FAIL mm_sda_oe_cycles got=%0d exp=%0d", oe_cnt, base_oe); end
    tests++; if (rxv_q.size() !== base_rx) begin fails++; $display("FAIL mm_rx_count got=%0d exp=%0d", rxv_q.size(), base_rx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mm_busy_stop got=%b exp=0", busy); end
  endtask

  task automatic test_read();
    int         base_tx;
    logic       ack;
    logic [7:0] d;
    base_tx = txr_cnt;
    tx_data = 8'h96;
    bus_start();
    byte_wr(8'hA1, ack);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL rd_addr_ack got=%b exp=0", ack); end
    tests++; if (txr_cnt - base_tx !== 1) begin fails++; $display("FAIL rd_txreq_addr got=%0d exp=1", txr_cnt - base_tx); end
    tests++; if (rw !== 1'b1) begin fails++; $display("FAIL rd_rw got=%b exp=1", rw); end
    tests++; if (addressed !== 1'b1) begin fails++; $display("FAIL rd_addressed got=%b exp=1", addressed); end
    tx_data = 8'h5A;
    byte_rd(1'b0, d);
    tests++; if (d !== 8'h96) begin fails++; $display("FAIL rd_byte0 got=%h exp=96", d); end
    tests++; if (txr_cnt - base_tx !== 2) begin fails++; $display("FAIL rd_txreq_byte0 got=%0d exp=2", txr_cnt - base_tx); end
    byte_rd(1'b1, d);
    tests++; if (d !== 8'h5A) begin fails++; $display("FAIL rd_byte1 got=%h exp=5a", d); end
    wait_clk(2);
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL rd_oe_after_nack got=%b exp=0", sda_oe); end
    bus_stop();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rd_busy_stop got=%b exp=0", busy); end
    tests++; if (rw !== 1'b1) begin fails++; $display("FAIL rd_rw_end got=%b exp=1", rw); end
  endtask

  task automatic test_back_to_back();
    int         base;
    logic       ack;
    logic [7:0] d;
    base = rxv_q.size();
    bus_start();
    byte_wr(8'hA0, ack);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL sr_addr0_ack got=%b exp=0", ack); end
    byte_wr(8'h11, ack);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL sr_data_ack got=%b exp=0", ack); end
    bus_start();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL sr_busy got=%b exp=1", busy); end
    tests++; if (addressed !== 1'b0) begin fails++; $display("FAIL sr_addressed got=%b exp=0", addressed); end
    tests++; if (rw !== 1'b0) begin fails++; $display("FAIL sr_rw_before got=%b exp=0", rw); end
    tx_data = 8'hE7;
    byte_wr(8'hA1, ack);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL sr_addr1_ack got=%b exp=0", ack); end
    tests++; if (rw !== 1'b1) begin fails++; $display("FAIL sr_rw_after got=%b exp=1", rw); end
    byte_rd(1'b1, d);
    tests++; if (d !== 8'hE7) begin fails++; $display("FAIL sr_rd_byte got=%h exp=e7", d); end
    bus_stop();
    tests++; if (rxv_q.size() - base !== 1) begin fails++; $display("FAIL sr_rx_count got=%0d exp=1", rxv_q.size() - base); end
    if (rxv_q.size() - base >= 1) begin
      tests++; if (rxv_q[base] !== 8'h11) begin fails++; $display("FAIL sr_rx0 got=%h exp=11", rxv_q[base]); end
    end
  endtask

  task automatic test_abort();
    int   base_rx, base_oe, base_tx;
    logic ack, s;
    // STOP after three data bits of a write.
    base_rx = rxv_q.size();
    bus_start();
    byte_wr(8'hA0, ack);
    bit_io(1'b1, s);
    bit_io(1'b0, s);
    bit_io(1'b1, s);
    bus_stop();
    tests++; if (rxv_q.size() !== base_rx) begin fails++; $display("FAIL ab_stop_rx got=%0d exp=%0d", rxv_q.size(), base_rx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ab_stop_busy got=%b exp=0", busy); end
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL ab_stop_oe got=%b exp=0", sda_oe); end
    // Reset pulse during bit 4 of a read while SDA is held low.
    tx_data = 8'h00;
    bus_start();
    byte_wr(8'hA1, ack);
    bit_io(1'b1, s);
    tests++; if (s !== 1'b0) begin fails++; $display("FAIL ab_rd_bit0 got=%b exp=0", s); end
    bit_io(1'b1, s);
    bit_io(1'b1, s);
    sda_m = 1'b1; wait_clk(4);
    scl = 1'b1; wait_clk(4);
    tests++; if (sda_oe !== 1'b1) begin fails++; $display("FAIL ab_oe_before_rst got=%b exp=1", sda_oe); end
    reset = 1'b1; wait_clk(1);
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL ab_oe_after_rst got=%b exp=0", sda_oe); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ab_busy_after_rst got=%b exp=0", busy); end
    tests++; if (rw !== 1'b0) begin fails++; $display("FAIL ab_rw_after_rst got=%b exp=0", rw); end
    reset = 1'b0;
    base_oe = oe_cnt;
    base_tx = txr_cnt;
    wait_clk(4);
    scl = 1'b0; wait_clk(4);
    for (int i = 0; i < 6; i++) bit_io(1'b1, s);
    tests++; if (oe_cnt !== base_oe) begin fails++; $display("FAIL ab_ignored_oe got=%0d exp=%0d", oe_cnt, base_oe); end
    tests++; if (txr_cnt !== base_tx) begin fails++; $display("FAIL ab_ignored_txreq got=%0d exp=%0d", txr_cnt, base_tx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ab_ignored_busy got=%b exp=0", busy); end
    bus_stop();
    bus_start();
    byte_wr(8'hA0, ack);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL ab_recover_ack got=%b exp=0", ack); end
    tests++; if (addressed !== 1'b1) begin fails++; $display("FAIL ab_recover_addressed got=%b exp=1", addressed); end
    bus_stop();
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
